// File: rtl/pito_ram_loader_pkg.sv
// Shared types and command constants for the pito RAM bootloader.
// Carries the loader FSM state and target encodings alongside the RV32 memory-port types.
package pito_ram_loader_pkg;

   typedef logic [31:0] rv32_data_t;
   typedef logic [10:0] rv32_imem_addr_t;
   typedef logic [10:0] rv32_dmem_addr_t;
   typedef logic [3:0]  imem_be_t;
   typedef logic [3:0]  dmem_be_t;

   localparam logic [7:0] LOADER_CMD_IMEM = 8'hA0;
   localparam logic [7:0] LOADER_CMD_DMEM = 8'hA1;

   typedef enum logic [2:0] {
      StIdle,
      StAddr0,
      StAddr1,
      StLen0,
      StLen1,
      StData,
      StWrite
   } loader_state_e;

   typedef enum logic {
      TgtImem,
      TgtDmem
   } loader_target_e;

   function automatic logic is_load_cmd(input logic [7:0] b);
      return (b == LOADER_CMD_IMEM) || (b == LOADER_CMD_DMEM);
   endfunction

endpackage

// File: rtl/pito_loader_word_asm.sv
// Little-endian byte-to-word assembler: byte i of each group of four lands in bits [8i+7:8i].
// word_valid flags the byte that completes the current word.
module pito_loader_word_asm
   import pito_ram_loader_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output rv32_data_t word,
   output logic       word_valid
);

   logic [1:0] idx_q;
   rv32_data_t word_q, word_d;

   always_comb begin
      word_d = word_q;
      word_d[{idx_q, 3'b000} +: 8] = byte_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         idx_q  <= 2'd0;
         word_q <= '0;
      end else if (byte_valid) begin
         idx_q  <= idx_q + 2'd1;
         word_q <= word_d;
      end
   end

   assign word       = word_q;
   assign word_valid = byte_valid && (idx_q == 2'd3);

endmodule

// File: rtl/pito_ram_loader.sv
// Framed UART bootloader driving the imem/dmem programming ports; holds cores during a frame.
// Optional inter-byte timeout abort is built when PITO_LOADER_TIMEOUT_EN is defined.
module pito_ram_loader
   import pito_ram_loader_pkg::*;
#(
   parameter int unsigned IMEM_AW        = 11,
   parameter int unsigned DMEM_AW        = 11,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   output rv32_data_t         imem_wdata,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_req,
   output logic               imem_we,
   output imem_be_t           imem_be,
   input  logic               imem_gnt,
   output rv32_data_t         dmem_wdata,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic               dmem_req,
   output logic               dmem_we,
   output dmem_be_t           dmem_be,
   input  logic               dmem_gnt,
   output logic               core_hold,
   output logic               done,
   output logic               err
);

   loader_state_e  state_q, state_d;
   loader_target_e target_q, target_d;
   logic [15:0]    addr_q, addr_d;
   logic [15:0]    len_q, len_d;
   logic           done_q, done_d;
   logic           err_q, err_d;

   logic               accept;
   logic               asm_valid;
   logic               word_valid;
   logic               abort;
   logic               gnt;
   logic               in_write;
   rv32_data_t         word;
   logic [IMEM_AW-1:0] imem_next;
   logic [DMEM_AW-1:0] dmem_next;

   assign rx_ready  = rst_n && (state_q != StWrite);
   assign accept    = rx_valid && rx_ready;
   assign asm_valid = accept && (state_q == StData);
   assign gnt       = (target_q == TgtImem) ? imem_gnt : dmem_gnt;
   assign imem_next = addr_q[IMEM_AW-1:0] + IMEM_AW'(1);
   assign dmem_next = addr_q[DMEM_AW-1:0] + DMEM_AW'(1);

   // Bits above the selected address width are carried but never reach a port.
   logic unused_addr;
   assign unused_addr = ^addr_q;

   pito_loader_word_asm u_word_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (abort),
      .byte_valid (asm_valid),
      .byte_data  (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

`ifdef PITO_LOADER_TIMEOUT_EN
   localparam int unsigned GapW = $clog2(TIMEOUT_CYCLES + 1);

   logic [GapW-1:0] gap_q, gap_d;

   // Gap counter is frozen while waiting on a grant: the stall is the memory's, not the host's.
   always_comb begin
      gap_d = gap_q;
      abort = 1'b0;
      if ((state_q == StIdle) || accept) begin
         gap_d = '0;
      end else if (state_q != StWrite) begin
         gap_d = gap_q + GapW'(1);
         if (gap_d == GapW'(TIMEOUT_CYCLES)) begin
            abort = 1'b1;
            gap_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`else
   assign abort = 1'b0;

   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      addr_d   = addr_q;
      len_d    = len_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_load_cmd(rx_data)) begin
                  target_d = (rx_data == LOADER_CMD_IMEM) ? TgtImem : TgtDmem;
                  state_d  = StAddr0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StAddr0: begin
            if (accept) begin
               addr_d  = {8'h00, rx_data};
               state_d = StAddr1;
            end
         end
         StAddr1: begin
            if (accept) begin
               addr_d[15:8] = rx_data;
               state_d      = StLen0;
            end
         end
         StLen0: begin
            if (accept) begin
               len_d   = {8'h00, rx_data};
               state_d = StLen1;
            end
         end
         StLen1: begin
            if (accept) begin
               len_d[15:8] = rx_data;
               if ({rx_data, len_q[7:0]} == 16'h0000) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (word_valid) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (gnt) begin
               addr_d = (target_q == TgtImem) ? 16'(imem_next) : 16'(dmem_next);
               len_d  = len_q - 16'd1;
               if (len_q == 16'd1) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  state_d = StData;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort) begin
         state_d = StIdle;
         err_d   = 1'b1;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         target_q <= TgtImem;
         addr_q   <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign in_write = (state_q == StWrite);

   always_comb begin
      imem_req   = in_write && (target_q == TgtImem);
      imem_we    = imem_req;
      imem_be    = {4{imem_req}};
      imem_addr  = imem_req ? addr_q[IMEM_AW-1:0] : '0;
      imem_wdata = imem_req ? word : '0;
      dmem_req   = in_write && (target_q == TgtDmem);
      dmem_we    = dmem_req;
      dmem_be    = {4{dmem_req}};
      dmem_addr  = dmem_req ? addr_q[DMEM_AW-1:0] : '0;
      dmem_wdata = dmem_req ? word : '0;
   end

   assign core_hold = (state_q != StIdle);
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pito_ram_loader.sv
// Directed bench for pito_ram_loader: framed writes, address wrap, bad command, grant stall,
// mid-frame reset, mid-frame stall and zero-length frame.
module tb_pito_ram_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] imem_wdata;
   logic [10:0] imem_addr;
   logic        imem_req;
   logic        imem_we;
   logic [3:0]  imem_be;
   logic        imem_gnt;
   logic [31:0] dmem_wdata;
   logic [10:0] dmem_addr;
   logic        dmem_req;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        core_hold;
   logic        done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;
   int err_snap;

   logic [31:0] log_mem[$];
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   logic [31:0] exp_mem[9]  = '{0, 0, 1, 1, 0, 0, 0, 1, 1};
   logic [31:0] exp_addr[9] = '{32'h010, 32'h011, 32'h7FF, 32'h000, 32'h100,
                                32'h020, 32'h021, 32'h040, 32'h050};
   logic [31:0] exp_data[9] = '{32'h12345678, 32'hDEADBEEF, 32'h44332211, 32'h88776655,
                                32'h04030201, 32'hDDCCBBAA, 32'h66778899, 32'h04030201,
                                32'h0A0B0C0D};

   pito_ram_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_wdata (imem_wdata),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_we    (imem_we),
      .imem_be    (imem_be),
      .imem_gnt   (imem_gnt),
      .dmem_wdata (dmem_wdata),
      .dmem_addr  (dmem_addr),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_be    (dmem_be),
      .dmem_gnt   (dmem_gnt),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_req && imem_gnt) begin
         log_mem.push_back(32'd0);
         log_addr.push_back(32'(imem_addr));
         log_data.push_back(imem_wdata);
      end
      if (dmem_req && dmem_gnt) begin
         log_mem.push_back(32'd1);
         log_addr.push_back(32'(dmem_addr));
         log_data.push_back(dmem_wdata);
      end
      if (done) n_done++;
      if (err) n_err++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] c, input logic [15:0] a, input logic [15:0] l);
      send_byte(c);
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(l[7:0]);
      send_byte(l[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         send_byte(w[8*i +: 8]);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      imem_gnt = 1'b1;
      dmem_gnt = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      chk("rst_outs", {25'd0, imem_req, dmem_req, imem_we, dmem_we, core_hold, done, err}, 32'd0);
      chk("rst_wdata", imem_wdata | dmem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

      // Two-word imem frame
      send_byte(8'hA0);
      chk("a_hold_after_cmd", {31'd0, core_hold}, 32'd1);
      send_byte(8'h10); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
      send_word(32'h12345678);
      chk("a_w0_req", {28'd0, imem_req, imem_we, dmem_req, core_hold}, 32'b1101);
      chk("a_w0_be", {28'd0, imem_be}, 32'hF);
      chk("a_w0_addr", 32'(imem_addr), 32'h010);
      chk("a_w0_data", imem_wdata, 32'h12345678);
      chk("a_w0_rx_ready", {31'd0, rx_ready}, 32'd0);
      send_word(32'hDEADBEEF);
      chk("a_w1_addr", 32'(imem_addr), 32'h011);
      chk("a_w1_data", imem_wdata, 32'hDEADBEEF);
      chk("a_w1_hold", {31'd0, core_hold}, 32'd1);
      @(negedge clk);
      chk("a_done", {30'd0, done, core_hold}, 32'b10);
      @(negedge clk);
      chk("a_done_pulse", {31'd0, done}, 32'd0);

      // Dmem frame wrapping at the top of the address space
      send_hdr(8'hA1, 16'h07FF, 16'd2);
      send_word(32'h44332211);
      chk("b_w0", {dmem_req, imem_req, 19'd0, dmem_addr}, {2'b10, 19'd0, 11'h7FF});
      send_word(32'h88776655);
      chk("b_w1", {dmem_req, imem_req, 19'd0, dmem_addr}, {2'b10, 19'd0, 11'h000});
      chk("b_w1_data", dmem_wdata, 32'h88776655);
      @(negedge clk);
      chk("b_done", {31'd0, done}, 32'd1);

      // Bad command in IDLE, then a normal frame
      send_byte(8'h55);
      chk("c_err", {29'd0, err, core_hold, imem_req}, 32'b100);
      @(negedge clk);
      chk("c_err_pulse", {31'd0, err}, 32'd0);
      send_hdr(8'hA0, 16'h0100, 16'd1);
      send_word(32'h04030201);
      chk("c_w_addr", 32'(imem_addr), 32'h100);
      @(negedge clk);
      chk("c_done", {31'd0, done}, 32'd1);

      // Grant held low for five cycles with a byte pending
      imem_gnt = 1'b0;
      send_hdr(8'hA0, 16'h0020, 16'd2);
      send_word(32'hDDCCBBAA);
      rx_data  = 8'h99;
      rx_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("d_stall_ctrl", {30'd0, rx_ready, imem_req}, 32'b01);
         chk("d_stall_addr", 32'(imem_addr), 32'h020);
         chk("d_stall_data", imem_wdata, 32'hDDCCBBAA);
         @(negedge clk);
      end
      imem_gnt = 1'b1;
      @(negedge clk);
      chk("d_after_gnt", {30'd0, rx_ready, imem_req}, 32'b10);
      @(negedge clk);
      rx_valid = 1'b0;
      send_byte(8'h88); send_byte(8'h77); send_byte(8'h66);
      chk("d_w1_addr", 32'(imem_addr), 32'h021);
      chk("d_w1_data", imem_wdata, 32'h66778899);
      @(negedge clk);
      chk("d_done", {31'd0, done}, 32'd1);

      // Reset after two data bytes discards the partial word
      send_hdr(8'hA0, 16'h0030, 16'd1);
      send_byte(8'h11); send_byte(8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      chk("e_rst_outs", {25'd0, imem_req, dmem_req, imem_we, dmem_we, core_hold, done, err},
          32'd0);
      chk("e_rst_misc", {20'd0, imem_be, dmem_be, 3'd0, rx_ready}, 32'd0);
      chk("e_rst_wdata", imem_wdata | dmem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      send_hdr(8'hA1, 16'h0040, 16'd1);
      send_word(32'h04030201);
      chk("e_w_addr", 32'(dmem_addr), 32'h040);
      chk("e_w_data", dmem_wdata, 32'h04030201);
      @(negedge clk);

      // Mid-frame stall waits indefinitely in the default build
      err_snap = n_err;
      send_byte(8'hA1); send_byte(8'h50);
      repeat (20) @(negedge clk);
      chk("f_wait", {30'd0, core_hold, rx_ready}, 32'b11);
      chk("f_no_err", 32'(n_err), 32'(err_snap));
      send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
      send_word(32'h0A0B0C0D);
      chk("f_w_addr", 32'(dmem_addr), 32'h050);
      @(negedge clk);

      // Zero-length frame completes without a write
      send_hdr(8'hA0, 16'h0005, 16'd0);
      chk("g_done", {30'd0, done, core_hold}, 32'b10);
      @(negedge clk);

      chk("log_size", 32'(log_data.size()), 32'd9);
      for (int i = 0; i < 9 && i < log_data.size(); i++) begin
         chk($sformatf("log%0d_mem", i), log_mem[i], exp_mem[i]);
         chk($sformatf("log%0d_addr", i), log_addr[i], exp_addr[i]);
         chk($sformatf("log%0d_data", i), log_data[i], exp_data[i]);
      end
      chk("done_count", 32'(n_done), 32'd7);
      chk("err_count", 32'(n_err), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pito_ram_loader.md
Name: pito_ram_loader

Overview:
- Byte-stream bootloader that sits upstream of the SoC external memory-programming port.
- Consumes bytes from a UART receiver over a valid/ready handshake and parses a framed write protocol.
- Assembles 32-bit little-endian words and drives the imem/dmem write channels (wdata/addr/req/we/be).
- Holds the cores in reset while a frame is in flight.

Parameters:
- IMEM_AW, 11, imem word-address width.
- DMEM_AW, 11, dmem word-address width.
- TIMEOUT_CYCLES, 100000, inter-byte gap limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- imem_wdata  out  32  instruction RAM write data
- imem_addr  out  IMEM_AW  instruction RAM word address
- imem_req  out  1  instruction RAM request
- imem_we  out  1  instruction RAM write enable
- imem_be  out  4  instruction RAM byte enables
- imem_gnt  in  1  instruction RAM accepted request
- dmem_wdata  out  32  data RAM write data
- dmem_addr  out  DMEM_AW  data RAM word address
- dmem_req  out  1  data RAM request
- dmem_we  out  1  data RAM write enable
- dmem_be  out  4  data RAM byte enables
- dmem_gnt  in  1  data RAM accepted request
- core_hold  out  1  high while a frame is active; gates core reset
- done  out  1  one-cycle pulse, frame completed
- err  out  1  one-cycle pulse, bad command or timeout

Behaviour:
- Byte transfer occurs when rx_valid && rx_ready.
- Frame format: CMD, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, then LEN×4 data bytes, LSB first per word.
  - CMD 0xA0 = imem, 0xA1 = dmem.
  - ADDR is the starting word address, truncated to IMEM_AW/DMEM_AW.
  - LEN is an unsigned 16-bit word count.
- Reset (rst_n=0 at a clk edge), from any state including mid-frame:
  - state=IDLE, rx_ready=0 during reset.
  - All req/we/be/wdata/addr, core_hold, done and err = 0.
  - Byte counter and word counter cleared.
  - Partial words are discarded; no write is issued.
- States: IDLE, ADDR0, ADDR1, LEN0, LEN1, DATA, WRITE.
  - IDLE: rx_ready=1.
    - Byte 0xA0/0xA1: latch target, go to ADDR0, core_hold=1 from next cycle.
    - Any other byte: err pulse next cycle, stay IDLE.
  - ADDR0 → ADDR1 → LEN0 → LEN1: one accepted byte per step; rx_ready=1.
  - LEN1: if the assembled LEN==0, go to IDLE with a done pulse and core_hold→0. Otherwise go to DATA.
  - DATA: rx_ready=1. The 2-bit byte index fills wdata[8i+7:8i]. On the 4th byte, go to WRITE.
  - WRITE: rx_ready=0.
    - The target's req=1, we=1, be=4'hF, addr=current word address. The non-target channel stays 0.
    - Held stable until gnt=1.
    - On gnt: word address +1, wrapping modulo 2^AW; remaining count −1.
    - If remaining count becomes 0: go to IDLE, done pulse, core_hold→0, all at the cycle after gnt. Otherwise go to DATA.
- Latency: req asserts the cycle after the 4th data byte is accepted. With gnt tied high, one word costs 4 byte cycles plus 1 write cycle.
- gnt arriving in the same cycle req first asserts counts as accepted.
- A byte offered during WRITE is not consumed; it stays pending on rx_valid.
- done and err never assert in the same cycle.

Optional Feature:
- Macro: PITO_LOADER_TIMEOUT_EN.
- Defined:
  - A gap counter runs in ADDR0..DATA while no byte is accepted.
  - Reaching TIMEOUT_CYCLES aborts to IDLE, pulses err, clears core_hold, and issues no write.
  - The counter is frozen in WRITE and cleared on every accepted byte.
- Undefined: no counter exists; the loader waits indefinitely mid-frame.

Decomposition:
- pito_pkg gains:
  - loader_state_e enum;
  - LOADER_CMD_IMEM=8'hA0 and LOADER_CMD_DMEM=8'hA1;
  - loader_target_e.
- rv32_data_t, rv32_imem_addr_t, rv32_dmem_addr_t and imem_be_t/dmem_be_t come from the existing packages.
- One natural sub-module: pito_loader_word_asm.
  - Byte-to-word shift register with 2-bit index and word_valid.
  - The FSM, counters and memory drive stay in the top module.

Test Plan:
- Frame A0 10 00 02 00, then 78 56 34 12 EF BE AD DE, gnt tied 1 → imem writes 0x12345678 @0x010 and 0xDEADBEEF @0x011; be=F; done pulse once; core_hold high from CMD+1 through last write.
- Frame A1 FF 07 02 00 + 8 bytes, DMEM_AW=11 → writes @0x7FF then @0x000 (wrap); imem_req stays 0.
- Byte 0x55 in IDLE → err pulse, no req, core_hold=0; a following valid A0 frame completes normally.
- gnt held low 5 cycles in WRITE with rx_valid=1 → rx_ready=0, req/addr/wdata stable for 5 cycles, next byte consumed only after gnt.
- rst_n=0 after 2 of 4 data bytes → all outputs 0 next cycle; a new frame then writes correctly from the new address.
- With PITO_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall 16 cycles after ADDR0 → err pulse, IDLE, no write. Without the macro, same stimulus → still in ADDR1 waiting.
